// File: rtl/afifo_pkg.sv
// Shared helpers for both pointer domains of the asynchronous FIFO.
// Gray conversions work on a wide vector; narrower pointers are zero-extended in and truncated out.
package afifo_pkg;

    localparam int ADDR_SIZE_DEF  = 3;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int GRAY_MAX_W     = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits pass through unchanged, so any width up to GRAY_MAX_W converts correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fwft_buf2.sv
// Two-entry FIFO-ordered output buffer presenting the head word as a valid/ready stream.
module fwft_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [1:0]            buf_cnt,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop_ok;

    assign out_valid = (buf_cnt != 2'd0);
    assign pop_ok    = pop & out_valid;
    assign out_data  = head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            buf_cnt <= 2'd0;
        end else begin
            case ({wr_en, pop_ok})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        head <= wr_data;
                    end else begin
                        tail <= wr_data;
                    end
                    if (buf_cnt != 2'd2) begin
                        buf_cnt <= buf_cnt + 2'd1;
                    end
                end
                2'b01: begin
                    head    <= tail;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy is unchanged, the queue shifts by one.
                    if (buf_cnt == 2'd1) begin
                        head <= wr_data;
                    end else begin
                        head <= tail;
                        tail <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/r_empty_fwft.sv
// Read-domain control of the async FIFO: read pointer, empty/almost_empty flags,
// memory fetch scheduling and a first-word-fall-through output stream.
module r_empty_fwft
    import afifo_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_SIZE:0]    w_ptr_sync,
    output logic [ADDR_SIZE:0]    r_ptr,
    output logic [ADDR_SIZE-1:0]  r_addr,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty,
    output logic                  almost_empty
);

    localparam int PW = ADDR_SIZE + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_bin_next;
    logic [PW-1:0] r_gray_next;
    logic [PW-1:0] w_bin_sync;
    logic [PW-1:0] fill_next;
    logic          infl;
    logic          fetch;
    logic          pop;
    logic [1:0]    buf_cnt;
    logic [2:0]    demand;

    assign w_bin_sync  = PW'(gray2bin(GRAY_MAX_W'(w_ptr_sync)));
    assign pop         = out_valid & out_ready;

    // Slots already claimed once this cycle's pop leaves; a fetch is allowed only into a free slot.
    assign demand      = {1'b0, buf_cnt} + {2'b00, infl} - {2'b00, pop};
    assign fetch       = !empty && (demand < 3'd2);
    assign mem_ren     = fetch;

    assign r_bin_next  = r_bin + PW'(fetch);
    assign r_gray_next = PW'(bin2gray(GRAY_MAX_W'(r_bin_next)));
    // Kept at pointer width so the subtraction wraps modulo 2^PW.
    assign fill_next   = w_bin_sync - r_bin_next;
    assign r_addr      = r_bin[ADDR_SIZE-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin        <= '0;
            r_ptr        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            infl         <= 1'b0;
        end else begin
            r_bin        <= r_bin_next;
            r_ptr        <= r_gray_next;
            empty        <= (r_gray_next == w_ptr_sync);
            almost_empty <= (fill_next <= PW'(AE_LEVEL));
            infl         <= fetch;
        end
    end

    fwft_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (infl),
        .wr_data   (mem_rdata),
        .pop       (pop),
        .buf_cnt   (buf_cnt),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_r_empty_fwft.sv
// Directed + randomized bench for r_empty_fwft against a word-count/queue reference model.
module tb_r_empty_fwft;

    localparam int AS = 3;
    localparam int DW = 8;
    localparam int AE = 2;
    localparam int DEPTH = 1 << AS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AS:0]   w_ptr_sync = '0;
    logic [AS:0]   r_ptr;
    logic [AS-1:0] r_addr;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          empty;
    logic          almost_empty;

    r_empty_fwft #(.ADDR_SIZE(AS), .DATA_WIDTH(DW), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .w_ptr_sync   (w_ptr_sync),
        .r_ptr        (r_ptr),
        .r_addr       (r_addr),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    // Dual-port memory model: registered read, data one cycle after the strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[r_addr];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int wcnt     = 0;     // words made visible to the read side
    int fcnt     = 0;     // fetch strobes observed
    int pops     = 0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [AS:0] gray(input int b);
        logic [AS:0] v;
        v = AS'(0) + (AS+1)'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wcnt % DEPTH] = d;
        exp_q.push_back(d);
        wcnt++;
        w_ptr_sync = gray(wcnt);
    endtask

    // Called at posedge+1: checks mid-cycle, crosses the edge, checks the registered flags.
    task automatic step();
        #3;
        chk("overflow_guard", 32'(dut.buf_cnt) + 32'(dut.infl) <= 2, 1);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("pop_data", out_data, exp_q.pop_front());
            pops++;
        end
        if (mem_ren) begin
            chk("fetch_addr", r_addr, fcnt % DEPTH);
            chk("fetch_room", wcnt > fcnt, 1);
            fcnt++;
        end
        @(posedge clk);
        #1;
        chk("empty_flag", empty, wcnt == fcnt);
        chk("ae_flag", almost_empty, (wcnt - fcnt) <= AE);
        chk("r_ptr", r_ptr, gray(fcnt));
    endtask

    task automatic model_reset();
        exp_q.delete();
        wcnt = 0;
        fcnt = 0;
        pops = 0;
        w_ptr_sync = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_ptr", r_ptr, 0);
        chk("rst_addr", r_addr, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b1;
    endtask

    initial begin
        int seen_valid;
        int bubbles;
        int sent;
        int guard;

        // Reset and idle: nothing may be fetched from an empty FIFO.
        do_reset();
        repeat (4) begin
            chk("idle_ren", mem_ren, 0);
            step();
        end

        // Single word: latency N+1 fetch, N+3 valid.
        push_word(8'hA5);
        #1;
        chk("n_ren", mem_ren, 0);
        step();
        chk("n1_empty", empty, 0);
        chk("n1_ren", mem_ren, 1);
        step();
        chk("n2_empty", empty, 1);
        chk("n2_valid", out_valid, 0);
        step();
        chk("n3_valid", out_valid, 1);
        chk("n3_data", out_data, 8'hA5);
        out_ready = 1'b1;
        step();
        chk("after_pop_valid", out_valid, 0);

        // Eight words, consumer always ready: no bubbles, pointer ends at Gray 8.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        chk("gray8", w_ptr_sync, 4'b1100);
        seen_valid = 0;
        bubbles = 0;
        for (int c = 0; c < 30 && pops < 8; c++) begin
            if (out_valid) seen_valid = 1;
            else if (seen_valid) bubbles++;
            step();
        end
        chk("burst_pops", pops, 8);
        chk("burst_bubbles", bubbles, 0);
        chk("burst_rptr", r_ptr, 4'b1100);
        chk("burst_empty", empty, 1);

        // Eight words, consumer stalled: only two fetches, head word held.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        repeat (10) step();
        chk("stall_fetches", fcnt, 2);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 8'h10);
        chk("stall_ae", almost_empty, 0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            step();
            guard++;
        end
        chk("stall_drained", exp_q.size(), 0);

        // Twenty random words in bursts across the pointer MSB wrap.
        sent = 0;
        guard = 0;
        while ((sent < 20 || exp_q.size() != 0) && guard < 3000) begin
            if (sent < 20 && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) begin
                    if (sent < 20 && (wcnt - fcnt) < DEPTH) begin
                        push_word(DW'($urandom_range(0, 255)));
                        sent++;
                    end
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        chk("rand_sent", sent, 20);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_wrapped", fcnt >= 2 * DEPTH, 1);

        // Reset in the middle of a transfer.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(8'hC0 + i));
        guard = 0;
        while (!(dut.infl && dut.buf_cnt != 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("mid_reached", dut.infl && dut.buf_cnt != 0, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_empty", empty, 1);
        chk("mid_ae", almost_empty, 1);
        chk("mid_ptr", r_ptr, 0);
        chk("mid_data", out_data, 0);
        chk("mid_ren", mem_ren, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_word(8'h3C);
        guard = 0;
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h3C);
        out_ready = 1'b1;
        step();
        chk("post_rst_pops", pops, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
